ram_arbiter_2port: RTL and testbench
====================================

# ram_arbiter_2port

Shares one downstream RAM port (the RAM_IF HOST-side signal set) between two requesters and inserts periodic refresh cycles. Port A (typically a VDP's video fetch) has fixed priority; port B (typically CPU/mapper access) has a starvation guard. The block sits between the cartridge cores and the RAM controller. Each transaction is latched at grant, so each host sees a simple request/one-cycle-acknowledge handshake.

## Interface
Parameters:
- ADDR_W, 24, address width on all ports
- MAX_A_BURST, 4, maximum consecutive A grants while B is waiting (must be ≥1)
- REFRESH_INTERVAL, 1024, CLK cycles between refresh requests (must be ≥16)

Ports:
- CLK  in  1  system clock
- RESET_n  in  1  asynchronous, active-low reset
- A_OE_n / B_OE_n  in  1  read request, active low
- A_WE_n / B_WE_n  in  1  write request, active low; OE_n and WE_n both low = read
- A_ADDR / B_ADDR  in  ADDR_W  address
- A_DIN / B_DIN  in  16  write data
- A_DIN_SIZE / B_DIN_SIZE  in  1  0 = byte (DIN[7:0]), 1 = word
- A_DOUT / B_DOUT  out  16  read data, valid while own ACK_n is low
- A_ACK_n / B_ACK_n  out  1  one-cycle completion pulse
- M_OE_n, M_WE_n, M_RFSH_n  out  1  downstream command
- M_ADDR  out  ADDR_W; M_DIN  out  16; M_DIN_SIZE  out  1
- M_DOUT  in  16  downstream read data, valid with M_ACK_n
- M_ACK_n  in  1  downstream completion, one-cycle low pulse

## Operation
- A host is requesting when OE_n or WE_n is low. The host holds its command stable until it sees its ACK_n. It deasserts in the cycle after the ACK.
- The FSM has four states: ARB, BUSY, RFSH, DONE. Reset state is ARB.
- In ARB, the winner is chosen in priority order:
  1. Pending refresh.
  2. B, if B is requesting and a_streak == MAX_A_BURST.
  3. A.
  4. B.
  
  If there is no request, the FSM stays in ARB.
- On a host grant, the winner's OE_n, WE_n, ADDR, DIN and DIN_SIZE are registered onto M_*. The FSM moves to BUSY. Host inputs are ignored until DONE.
- On a refresh grant, the FSM drives M_RFSH_n=0 with M_OE_n=M_WE_n=1, clears rfsh_pend, and moves to RFSH.
- BUSY/RFSH: M_* are held until M_ACK_n=0. On that cycle, M_DOUT is registered into the granted host's DOUT, the FSM moves to DONE, and M_* return to idle (all command lines 1, ADDR/DIN 0).
- DONE: the granted host's ACK_n=0 for exactly this cycle. No arbitration takes place. Next state is ARB.
- a_streak (width clog2(MAX_A_BURST+1)):
  - Increments on an A grant while B is requesting, saturating at MAX_A_BURST.
  - Clears on a B grant.
  - Clears in any ARB cycle where B is not requesting.
  - Refresh grants leave it unchanged.
- Refresh counter: counts down every CLK in every state. On reaching 0 it reloads REFRESH_INTERVAL-1 and sets rfsh_pend. If rfsh_pend is already set, the new request merges (at most one pending).
- Write data: for byte writes M_DIN carries DIN unchanged; the RAM controller uses DIN_SIZE. Read DOUT is passed unchanged.
- Reset values:
  - All *_ACK_n = 1, M_OE_n = M_WE_n = M_RFSH_n = 1.
  - M_ADDR, M_DIN, M_DIN_SIZE, A_DOUT, B_DOUT = 0.
  - a_streak = 0, rfsh_pend = 0, counter = REFRESH_INTERVAL-1.
- Asserting reset mid-transaction abandons the transaction immediately. Outputs go to their reset values, and any late M_ACK_n after reset is ignored in ARB.
- A M_ACK_n pulse arriving in ARB or DONE is ignored.

## Timing
- Request visible in ARB at cycle 0 → M_* driven from cycle 1.
- M_ACK_n low at cycle k (k ≥ 1) → host ACK_n low and DOUT valid at cycle k+1 → ARB again at k+2.
- Minimum grant-to-grant spacing is 3 cycles with a zero-wait RAM controller.
- A refresh that becomes pending during BUSY is served at the next ARB, ahead of any host.
- M_* change only on CLK edges; there are no combinational paths from host inputs to M_*.

## Test plan
- Single A read at 0x001234, with M_ACK_n returned 2 cycles after M_OE_n falls and M_DOUT=0xBEEF → M_ADDR=0x001234 from cycle 1, A_ACK_n low one cycle with A_DOUT=0xBEEF, B_ACK_n stays 1.
- A and B both requesting continuously, MAX_A_BURST=4 → grant sequence A,A,A,A,B,A,A,A,A,B; a_streak clears after each B.
- Only B writes 0x00AA (byte) to 0x000010 → M_WE_n=0, M_OE_n=1, M_DIN_SIZE=0, M_DIN=0x00AA; B_ACK_n pulses once.
- REFRESH_INTERVAL=16 with A requesting continuously → M_RFSH_n low with M_OE_n=M_WE_n=1 once per 16-cycle window, granted before A at the next ARB; never two refreshes back-to-back without an intervening expiry.
- RESET_n pulsed low while in BUSY → all outputs return to reset values within the same cycle (asynchronous). A subsequent stray M_ACK_n causes no host ACK. A new A request completes normally.
- M_ACK_n pulsed while idle in ARB → no host ACK, FSM stays in ARB.

Source files
------------

// File: rtl/ram_arbiter_2port.sv
// Two-requester RAM port arbiter with periodic refresh insertion.
// Port A has fixed priority; port B is protected by an A-streak limit.
module ram_arbiter_2port #(
    parameter int ADDR_W           = 24,
    parameter int MAX_A_BURST      = 4,
    parameter int REFRESH_INTERVAL = 1024
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              A_OE_n,
    input  logic              A_WE_n,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [15:0]       A_DIN,
    input  logic              A_DIN_SIZE,
    output logic [15:0]       A_DOUT,
    output logic              A_ACK_n,
    input  logic              B_OE_n,
    input  logic              B_WE_n,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [15:0]       B_DIN,
    input  logic              B_DIN_SIZE,
    output logic [15:0]       B_DOUT,
    output logic              B_ACK_n,
    output logic              M_OE_n,
    output logic              M_WE_n,
    output logic              M_RFSH_n,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [15:0]       M_DIN,
    output logic              M_DIN_SIZE,
    input  logic [15:0]       M_DOUT,
    input  logic              M_ACK_n
);
    localparam logic [1:0] ST_ARB  = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RFSH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int SW = $clog2(MAX_A_BURST + 1);
    localparam int CW = $clog2(REFRESH_INTERVAL);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_A_BURST);
    localparam logic [CW-1:0] RCNT_LOAD  = CW'(REFRESH_INTERVAL - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_b_q, owner_b_d;
    logic [SW-1:0]     a_streak_q, a_streak_d;
    logic              rfsh_pend_q, rfsh_pend_d;
    logic [CW-1:0]     rcnt_q, rcnt_d;
    logic              m_oe_n_q, m_oe_n_d;
    logic              m_we_n_q, m_we_n_d;
    logic              m_rfsh_n_q, m_rfsh_n_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [15:0]       m_din_q, m_din_d;
    logic              m_size_q, m_size_d;
    logic [15:0]       a_dout_q, a_dout_d;
    logic [15:0]       b_dout_q, b_dout_d;
    logic              a_ack_n_q, a_ack_n_d;
    logic              b_ack_n_q, b_ack_n_d;

    logic a_req, b_req, grant_host, grant_b;

    // Next-state logic: arbitration, transaction tracking, refresh timer.
    always_comb begin
        a_req       = !A_OE_n || !A_WE_n;
        b_req       = !B_OE_n || !B_WE_n;
        grant_host  = 1'b0;
        grant_b     = 1'b0;
        state_d     = state_q;
        owner_b_d   = owner_b_q;
        a_streak_d  = a_streak_q;
        rfsh_pend_d = rfsh_pend_q;
        m_oe_n_d    = m_oe_n_q;
        m_we_n_d    = m_we_n_q;
        m_rfsh_n_d  = m_rfsh_n_q;
        m_addr_d    = m_addr_q;
        m_din_d     = m_din_q;
        m_size_d    = m_size_q;
        a_dout_d    = a_dout_q;
        b_dout_d    = b_dout_q;
        a_ack_n_d   = 1'b1;
        b_ack_n_d   = 1'b1;

        if (rcnt_q == '0) begin
            rcnt_d = RCNT_LOAD;
        end else begin
            rcnt_d = rcnt_q - 1'b1;
        end

        unique case (state_q)
            ST_ARB: begin
                if (!b_req) begin
                    a_streak_d = '0;
                end
                if (rfsh_pend_q) begin
                    rfsh_pend_d = 1'b0;
                    m_rfsh_n_d  = 1'b0;
                    state_d     = ST_RFSH;
                end else if (b_req && a_streak_q == STREAK_MAX) begin
                    grant_host = 1'b1;
                    grant_b    = 1'b1;
                end else if (a_req) begin
                    grant_host = 1'b1;
                    if (b_req && a_streak_q != STREAK_MAX) begin
                        a_streak_d = a_streak_q + 1'b1;
                    end
                end else if (b_req) begin
                    grant_host = 1'b1;
                    grant_b    = 1'b1;
                end
                if (grant_host) begin
                    state_d   = ST_BUSY;
                    owner_b_d = grant_b;
                    m_oe_n_d  = grant_b ? B_OE_n : A_OE_n;
                    m_we_n_d  = grant_b ? B_WE_n : A_WE_n;
                    m_addr_d  = grant_b ? B_ADDR : A_ADDR;
                    m_din_d   = grant_b ? B_DIN : A_DIN;
                    m_size_d  = grant_b ? B_DIN_SIZE : A_DIN_SIZE;
                    if (grant_b) begin
                        a_streak_d = '0;
                    end
                end
            end
            ST_BUSY, ST_RFSH: begin
                if (!M_ACK_n) begin
                    if (state_q == ST_BUSY) begin
                        if (owner_b_q) begin
                            b_dout_d  = M_DOUT;
                            b_ack_n_d = 1'b0;
                        end else begin
                            a_dout_d  = M_DOUT;
                            a_ack_n_d = 1'b0;
                        end
                    end
                    state_d    = ST_DONE;
                    m_oe_n_d   = 1'b1;
                    m_we_n_d   = 1'b1;
                    m_rfsh_n_d = 1'b1;
                    m_addr_d   = '0;
                    m_din_d    = '0;
                    m_size_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_ARB;
            end
        endcase

        if (rcnt_q == '0) begin
            rfsh_pend_d = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= ST_ARB;
            owner_b_q   <= 1'b0;
            a_streak_q  <= '0;
            rfsh_pend_q <= 1'b0;
            rcnt_q      <= RCNT_LOAD;
            m_oe_n_q    <= 1'b1;
            m_we_n_q    <= 1'b1;
            m_rfsh_n_q  <= 1'b1;
            m_addr_q    <= '0;
            m_din_q     <= '0;
            m_size_q    <= 1'b0;
            a_dout_q    <= '0;
            b_dout_q    <= '0;
            a_ack_n_q   <= 1'b1;
            b_ack_n_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            owner_b_q   <= owner_b_d;
            a_streak_q  <= a_streak_d;
            rfsh_pend_q <= rfsh_pend_d;
            rcnt_q      <= rcnt_d;
            m_oe_n_q    <= m_oe_n_d;
            m_we_n_q    <= m_we_n_d;
            m_rfsh_n_q  <= m_rfsh_n_d;
            m_addr_q    <= m_addr_d;
            m_din_q     <= m_din_d;
            m_size_q    <= m_size_d;
            a_dout_q    <= a_dout_d;
            b_dout_q    <= b_dout_d;
            a_ack_n_q   <= a_ack_n_d;
            b_ack_n_q   <= b_ack_n_d;
        end
    end

    assign M_OE_n     = m_oe_n_q;
    assign M_WE_n     = m_we_n_q;
    assign M_RFSH_n   = m_rfsh_n_q;
    assign M_ADDR     = m_addr_q;
    assign M_DIN      = m_din_q;
    assign M_DIN_SIZE = m_size_q;
    assign A_DOUT     = a_dout_q;
    assign B_DOUT     = b_dout_q;
    assign A_ACK_n    = a_ack_n_q;
    assign B_ACK_n    = b_ack_n_q;
endmodule

// File: tb/tb_ram_arbiter_2port.sv
// Bench for ram_arbiter_2port: directed steps plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_ram_arbiter_2port;
    localparam int AW   = 24;
    localparam int MAXB = 4;
    localparam int RI   = 16;

    logic CLK = 1'b0;
    logic RESET_n = 1'b0;
    logic A_OE_n = 1, A_WE_n = 1, A_DIN_SIZE = 0;
    logic B_OE_n = 1, B_WE_n = 1, B_DIN_SIZE = 0;
    logic [AW-1:0] A_ADDR = '0, B_ADDR = '0;
    logic [15:0] A_DIN = '0, B_DIN = '0;
    logic [15:0] M_DOUT = '0;
    logic M_ACK_n = 1'b1;
    logic [15:0] A_DOUT, B_DOUT, M_DIN;
    logic A_ACK_n, B_ACK_n, M_OE_n, M_WE_n, M_RFSH_n, M_DIN_SIZE;
    logic [AW-1:0] M_ADDR;

    always #5 CLK = ~CLK;

    ram_arbiter_2port #(
        .ADDR_W(AW), .MAX_A_BURST(MAXB), .REFRESH_INTERVAL(RI)
    ) dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .A_OE_n(A_OE_n), .A_WE_n(A_WE_n), .A_ADDR(A_ADDR),
        .A_DIN(A_DIN), .A_DIN_SIZE(A_DIN_SIZE),
        .A_DOUT(A_DOUT), .A_ACK_n(A_ACK_n),
        .B_OE_n(B_OE_n), .B_WE_n(B_WE_n), .B_ADDR(B_ADDR),
        .B_DIN(B_DIN), .B_DIN_SIZE(B_DIN_SIZE),
        .B_DOUT(B_DOUT), .B_ACK_n(B_ACK_n),
        .M_OE_n(M_OE_n), .M_WE_n(M_WE_n), .M_RFSH_n(M_RFSH_n),
        .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_DIN_SIZE(M_DIN_SIZE),
        .M_DOUT(M_DOUT), .M_ACK_n(M_ACK_n)
    );

    int n_assert = 0;
    int n_fail = 0;

    // reference model: phase 0 = arbitrating, 1 = waiting on RAM, 2 = done
    int ph, who, streak, edges;
    bit pend;
    logic e_moe, e_mwe, e_mrf, e_sz, e_aa, e_ba;
    logic [AW-1:0] e_addr;
    logic [15:0] e_din, e_ad, e_bd;

    // RAM responder and host generators
    bit ram_busy = 0, ram_acked = 0, ram_fix = 0, stray_n = 1;
    int ram_cnt = 0, ram_dly = -1;
    logic [15:0] ram_fix_val = '0, ram_last = '0;
    bit auto_h = 0, a_act = 0, b_act = 0;
    int a_left = 0, b_left = 0, a_prob = 100, b_prob = 100;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; who = 0; streak = 0; edges = 0; pend = 0;
        e_moe = 1; e_mwe = 1; e_mrf = 1; e_sz = 0;
        e_aa = 1; e_ba = 1; e_addr = '0; e_din = '0;
        e_ad = '0; e_bd = '0;
    endtask

    task automatic take(input bit isb);
        who    = isb ? 1 : 0;
        e_moe  = isb ? B_OE_n : A_OE_n;
        e_mwe  = isb ? B_WE_n : A_WE_n;
        e_addr = isb ? B_ADDR : A_ADDR;
        e_din  = isb ? B_DIN : A_DIN;
        e_sz   = isb ? B_DIN_SIZE : A_DIN_SIZE;
        ph     = 1;
    endtask

    task automatic model_step();
        bit ar, br, np;
        ar = !A_OE_n || !A_WE_n;
        br = !B_OE_n || !B_WE_n;
        edges++;
        np = (edges % RI) == 0;
        e_aa = 1; e_ba = 1;
        if (ph == 0) begin
            if (!br) streak = 0;
            if (pend) begin
                pend = 0; who = 2; e_mrf = 0; ph = 1;
            end else if (br && streak == MAXB) begin
                take(1); streak = 0;
            end else if (ar) begin
                take(0);
                if (br) streak = (streak < MAXB) ? streak + 1 : MAXB;
            end else if (br) begin
                take(1); streak = 0;
            end
        end else if (ph == 1) begin
            if (!M_ACK_n) begin
                if (who == 0) begin e_ad = M_DOUT; e_aa = 0; end
                if (who == 1) begin e_bd = M_DOUT; e_ba = 0; end
                e_moe = 1; e_mwe = 1; e_mrf = 1; e_sz = 0;
                e_addr = '0; e_din = '0; ph = 2;
            end
        end else begin
            ph = 0;
        end
        if (np) pend = 1;
    endtask

    task automatic check_all();
        chk("m_oe_n", M_OE_n, e_moe);
        chk("m_we_n", M_WE_n, e_mwe);
        chk("m_rfsh_n", M_RFSH_n, e_mrf);
        chk("m_addr", M_ADDR, e_addr);
        chk("m_din", M_DIN, e_din);
        chk("m_din_size", M_DIN_SIZE, e_sz);
        chk("a_ack_n", A_ACK_n, e_aa);
        chk("b_ack_n", B_ACK_n, e_ba);
        chk("a_dout", A_DOUT, e_ad);
        chk("b_dout", B_DOUT, e_bd);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_a_ack_n"}, A_ACK_n, 1);
        chk({p, "_b_ack_n"}, B_ACK_n, 1);
        chk({p, "_m_oe_n"}, M_OE_n, 1);
        chk({p, "_m_we_n"}, M_WE_n, 1);
        chk({p, "_m_rfsh_n"}, M_RFSH_n, 1);
        chk({p, "_m_addr"}, M_ADDR, 0);
        chk({p, "_m_din"}, M_DIN, 0);
        chk({p, "_m_size"}, M_DIN_SIZE, 0);
        chk({p, "_a_dout"}, A_DOUT, 0);
        chk({p, "_b_dout"}, B_DOUT, 0);
    endtask

    task automatic ram_drive();
        bit cmd;
        cmd = !M_OE_n || !M_WE_n || !M_RFSH_n;
        if (ram_acked) begin
            ram_acked = 0; ram_busy = 0; M_ACK_n = 1;
        end else if (cmd) begin
            if (!ram_busy) begin
                ram_busy = 1;
                ram_cnt = (ram_dly < 0) ? int'($urandom_range(3, 0)) : ram_dly;
            end
            if (ram_cnt == 0) begin
                M_DOUT = ram_fix ? ram_fix_val : 16'($urandom);
                ram_last = M_DOUT;
                M_ACK_n = 0;
                ram_acked = 1;
            end else begin
                ram_cnt--;
            end
        end else begin
            M_ACK_n = stray_n;
            if (!stray_n) M_DOUT = 16'($urandom);
        end
    endtask

    task automatic rnd_cmd(output logic oe, output logic we);
        int r;
        r = int'($urandom_range(2, 0));
        oe = (r == 1);
        we = (r == 0);
    endtask

    task automatic host_drive();
        if (a_act && !A_ACK_n) begin
            a_act = 0; A_OE_n = 1; A_WE_n = 1; a_left--;
        end
        if (!a_act && a_left > 0 && $urandom_range(99, 0) < a_prob) begin
            a_act = 1;
            rnd_cmd(A_OE_n, A_WE_n);
            A_ADDR = {1'b0, 23'($urandom)};
            A_DIN = 16'($urandom);
            A_DIN_SIZE = 1'($urandom);
        end
        if (b_act && !B_ACK_n) begin
            b_act = 0; B_OE_n = 1; B_WE_n = 1; b_left--;
        end
        if (!b_act && b_left > 0 && $urandom_range(99, 0) < b_prob) begin
            b_act = 1;
            rnd_cmd(B_OE_n, B_WE_n);
            B_ADDR = {1'b1, 23'($urandom)};
            B_DIN = 16'($urandom);
            B_DIN_SIZE = 1'($urandom);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        if (RESET_n) model_step();
        check_all();
        ram_drive();
        if (auto_h) host_drive();
    endtask

    initial begin
        int n, pulses, rf, cyc;
        bit hc, prev_hc, prev_rf;
        string seq;

        repeat (2) @(negedge CLK);
        chk_reset_vals("rst0");
        model_reset();
        RESET_n = 1;

        // single A read
        ram_dly = 2; ram_fix = 1; ram_fix_val = 16'hBEEF;
        A_ADDR = 24'h001234; A_OE_n = 0;
        tick();
        chk("ard_maddr", M_ADDR, 24'h001234);
        chk("ard_moe", M_OE_n, 0);
        n = 1;
        while (A_ACK_n && n < 20) begin tick(); n++; end
        chk("ard_latency", n, 4);
        chk("ard_dout", A_DOUT, 16'hBEEF);
        chk("ard_back", B_ACK_n, 1);
        A_OE_n = 1;
        tick();
        chk("ard_ack_1cyc", A_ACK_n, 1);

        // B byte write
        ram_dly = 0; ram_fix = 0;
        B_WE_n = 0; B_ADDR = 24'h000010; B_DIN = 16'h00AA; B_DIN_SIZE = 0;
        tick();
        chk("bwr_mwe", M_WE_n, 0);
        chk("bwr_moe", M_OE_n, 1);
        chk("bwr_size", M_DIN_SIZE, 0);
        chk("bwr_din", M_DIN, 16'h00AA);
        chk("bwr_addr", M_ADDR, 24'h000010);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!B_ACK_n) begin pulses++; B_WE_n = 1; end
        end
        chk("bwr_pulses", pulses, 1);

        // random traffic
        ram_dly = -1;
        auto_h = 1; a_prob = 60; b_prob = 60; a_left = 200; b_left = 200;
        cyc = 0;
        while (!(a_left <= 0 && b_left <= 0 && !a_act && !b_act) && cyc < 8000) begin
            tick(); cyc++;
        end
        chk("rand_drain", cyc < 8000, 1);
        repeat (4) tick();

        // continuous A and B: grant order
        a_prob = 100; b_prob = 100; a_left = 1000; b_left = 1000;
        seq = ""; prev_hc = 0; cyc = 0;
        while (seq.len() < 10 && cyc < 400) begin
            tick(); cyc++;
            hc = !M_OE_n || !M_WE_n;
            if (hc && !prev_hc) seq = {seq, M_ADDR[AW-1] ? "B" : "A"};
            prev_hc = hc;
        end
        n_assert++;
        assert (seq == "AAAABAAAAB") else begin
            n_fail++;
            $error("FAIL grant_seq observed=%s expected=AAAABAAAAB", seq);
        end

        // A only: refresh cadence
        b_left = 0; cyc = 0;
        while (b_act && cyc < 50) begin tick(); cyc++; end
        rf = 0; prev_rf = 0;
        for (int i = 0; i < 160; i++) begin
            tick();
            if (!M_RFSH_n && !prev_rf) rf++;
            prev_rf = !M_RFSH_n;
        end
        chk("rfsh_count_ok", (rf >= 9 && rf <= 11), 1);
        a_left = 0; cyc = 0;
        while (a_act && cyc < 50) begin tick(); cyc++; end
        auto_h = 0;
        repeat (3) tick();

        // reset in the middle of a transaction
        ram_dly = 3;
        A_ADDR = 24'h00ABCD; A_OE_n = 0;
        cyc = 0;
        while (M_OE_n && cyc < 20) begin tick(); cyc++; end
        tick();
        #2 RESET_n = 0;
        #1 chk_reset_vals("rstb");
        model_reset();
        ram_busy = 0; ram_acked = 0; M_ACK_n = 1;
        A_OE_n = 1;
        repeat (2) tick();
        RESET_n = 1;
        tick();
        stray_n = 0;
        tick();
        stray_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray_a_ack", A_ACK_n, 1);
            chk("stray_b_ack", B_ACK_n, 1);
        end
        ram_dly = 1;
        A_ADDR = 24'h000777; A_OE_n = 0;
        n = 0;
        while (A_ACK_n && n < 20) begin tick(); n++; end
        chk("post_rst_a_ack", A_ACK_n, 0);
        chk("post_rst_a_dout", A_DOUT, ram_last);
        A_OE_n = 1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
